// File: rtl/dcache_pkg.sv
// Shared definitions for the write-through direct-mapped data cache:
// default geometry, MMIO region decode, FSM encoding and field-width helpers.
package dcache_pkg;

  localparam int LINES_DEF      = 64;
  localparam int LINE_WORDS_DEF = 4;

  // addr[31:28] value that marks an uncached, single-word MMIO access
  localparam logic [3:0] MMIO_REGION = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_REFILL   = 3'd2,
    ST_WREQ     = 3'd3,
    ST_UNC_WAIT = 3'd4,
    ST_RESP     = 3'd5
  } state_e;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int line_words);
    return 32 - 2 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Data array of the cache: one write port with per-byte enables and one
// asynchronous read port, so a hit can return its word in the compare cycle.
module dcache_data_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata
);
  localparam int DEPTH = 1 << AW;

  logic [31:0] mem_q [DEPTH];

  // Byte-lane writes; contents need no reset because valid bits guard them
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wbe[b]) mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dcache_wt_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Hits answer in the cycle after acceptance; misses refill a whole line
// with a word-serial burst; stores and MMIO always go to memory.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
// Memory request handshake: mem_req_valid is held with every mem_req_*
// field stable until the cycle where mem_req_valid & mem_req_ready, which
// is the transfer; read beats arrive on mem_resp_valid with no back-pressure.
module dcache_wt_dm
  import dcache_pkg::*;
#(
  parameter int LINES      = LINES_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_re,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_din,
  output logic [31:0] cpu_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_burst,
  output logic [31:0] mem_req_addr,
  output logic [3:0]  mem_req_wmask,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output state_e      dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int WB  = word_bits(LINE_WORDS);
  localparam int IB  = index_bits(LINES);
  localparam int TB  = tag_bits(LINES, LINE_WORDS);
  localparam int RAW = IB + WB;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       we_q, we_d;
  logic [31:0]      din_q, din_d;
  logic             pend_q, pend_d;
  logic [WB-1:0]    cnt_q, cnt_d;
  logic [31:0]      resp_q, resp_d;
  logic [31:0]      last_q, last_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [TB-1:0]    tag_q [LINES];
  logic             tag_we;
  logic             accept;

  logic [WB-1:0]    req_word;
  logic [IB-1:0]    req_idx;
  logic [TB-1:0]    req_tag;
  logic             is_mmio, is_store, hit;

  logic [RAW-1:0]   ram_waddr;
  logic [3:0]       ram_wbe;
  logic [31:0]      ram_wdata, ram_rdata;
  logic             unused_addr_bits;

  assign req_word  = addr_q[2 +: WB];
  assign req_idx   = addr_q[2+WB +: IB];
  assign req_tag   = addr_q[31 -: TB];
  assign is_mmio   = (addr_q[31:28] == MMIO_REGION);
  assign is_store  = |we_q;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !is_mmio;
  assign dbg_state = state_q;
  assign unused_addr_bits = ^addr_q[1:0];

  dcache_data_ram #(.AW(RAW)) u_data (
    .clk   (clk),
    .raddr ({req_idx, req_word}),
    .rdata (ram_rdata),
    .waddr (ram_waddr),
    .wbe   (ram_wbe),
    .wdata (ram_wdata)
  );

  // Next-state, memory request, data-array write and core-facing outputs
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    we_d          = we_q;
    din_d         = din_q;
    pend_d        = 1'b0;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    valid_d       = valid_q;
    tag_we        = 1'b0;
    stall         = 1'b0;
    cpu_dout      = last_q;
    mem_req_valid = 1'b0;
    mem_req_burst = 1'b0;
    mem_req_addr  = {addr_q[31:2], 2'b00};
    mem_req_wmask = 4'h0;
    mem_req_wdata = din_q;
    ram_waddr     = {req_idx, req_word};
    ram_wbe       = 4'h0;
    ram_wdata     = din_q;
    case (state_q)
      ST_IDLE: begin
        // Only loads are pending here; stores go straight to WREQ
        if (pend_q) begin
          if (hit) begin
            cpu_dout = ram_rdata;
          end else begin
            stall   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_burst = !is_mmio;
        if (!is_mmio) mem_req_addr = {addr_q[31:2+WB], {(WB+2){1'b0}}};
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = is_mmio ? ST_UNC_WAIT : ST_REFILL;
        end
      end
      ST_REFILL: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          ram_waddr = {req_idx, cnt_q};
          ram_wbe   = 4'hF;
          ram_wdata = mem_resp_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == req_word) resp_d = mem_resp_data;
          // Line becomes valid only once every beat has landed
          if (cnt_q == WB'(LINE_WORDS - 1)) begin
            valid_d[req_idx] = 1'b1;
            tag_we           = 1'b1;
            state_d          = ST_RESP;
          end
        end
      end
      ST_WREQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_wmask = we_q;
        if (mem_req_ready) begin
          if (hit) ram_wbe = we_q;
          state_d = ST_RESP;
        end
      end
      ST_UNC_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          resp_d  = mem_resp_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!is_store) cpu_dout = resp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // New request; a set store mask takes precedence over cpu_re
    accept = (cpu_re | (|cpu_we)) & ~stall;
    if (accept) begin
      addr_d  = cpu_addr;
      we_d    = cpu_we;
      din_d   = cpu_din;
      pend_d  = ~(|cpu_we);
      state_d = (|cpu_we) ? ST_WREQ : ST_IDLE;
    end
    last_d = cpu_dout;
  end

  // Control state with asynchronous clear of FSM, request and valid bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= '0;
      din_q   <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      resp_q  <= '0;
      last_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      din_q   <= din_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  // Tag store, written when a refill completes
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[req_idx] <= req_tag;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d;
  logic        load_hit, load_miss;

  assign load_hit  = (state_q == ST_IDLE) && pend_q && hit;
  assign load_miss = (state_q == ST_IDLE) && pend_q && !hit && !is_mmio;

  // Saturating counters for cacheable load outcomes
  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    if (load_hit  && (hits_q   != '1)) hits_d   = hits_q + 32'd1;
    if (load_miss && (misses_q != '1)) misses_d = misses_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
`endif

endmodule

// File: tb/tb_dcache_wt_dm.sv
// Directed bench for dcache_wt_dm: inputs change and outputs are sampled on
// the falling clock edge; memory is played by hand-timed driver tasks.
module tb_dcache_wt_dm;
  import dcache_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_burst;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  state_e      dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits;
  logic [31:0] stat_misses;
`endif

  int checks;
  int failures;

  dcache_wt_dm dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_addr       (cpu_addr),
    .cpu_re         (cpu_re),
    .cpu_we         (cpu_we),
    .cpu_din        (cpu_din),
    .cpu_dout       (cpu_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_burst  (mem_req_burst),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wmask  (mem_req_wmask),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state      (dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits      (stat_hits),
    .stat_misses    (stat_misses)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a memory request to be presented
  task automatic wait_req(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_req_seen"}, 32'(ok), 32'd1);
  endtask

  // Cacheable load that must miss: checks stall, burst request, refill, RESP
  task automatic load_miss(input logic [31:0] addr, input logic [31:0] beat0,
                           input logic [31:0] exp_dout, input logic [31:0] exp_line,
                           input string tag);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    @(negedge clk);
    check({tag, "_stall_t1"}, 32'(stall), 32'd1);
    cpu_re = 1'b0;
    @(negedge clk);
    wait_req(tag);
    check({tag, "_burst"}, 32'(mem_req_burst), 32'd1);
    check({tag, "_addr"}, mem_req_addr, exp_line);
    check({tag, "_wmask"}, 32'(mem_req_wmask), 32'd0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = beat0 + 32'(i);
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_dout"}, cpu_dout, exp_dout);
    @(negedge clk);
  endtask

  // Load that must hit: data in T+1, no stall, no memory traffic
  task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp_dout, input string tag);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    @(negedge clk);
    cpu_re = 1'b0;
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_dout"}, cpu_dout, exp_dout);
    check({tag, "_noreq"}, 32'(mem_req_valid), 32'd0);
    @(negedge clk);
  endtask

  // Store with memory ready withheld for 'delay' cycles
  task automatic do_store(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] din,
                          input int delay, input int exp_cycles, input string tag);
    int n;
    n        = 0;
    cpu_addr = addr;
    cpu_we   = we;
    cpu_din  = din;
    @(negedge clk);
    check({tag, "_valid"}, 32'(mem_req_valid), 32'd1);
    check({tag, "_wmask"}, 32'(mem_req_wmask), 32'(we));
    check({tag, "_addr"}, mem_req_addr, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, mem_req_wdata, din);
    for (int i = 0; i < 20 && stall; i++) begin
      n++;
      if (i == delay) begin
        mem_req_ready = 1'b1;
        cpu_we        = 4'h0;
      end
      @(negedge clk);
      mem_req_ready = 1'b0;
    end
    cpu_we = 4'h0;
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_cycles));
    check({tag, "_stall_after"}, 32'(stall), 32'd0);
    @(negedge clk);
  endtask

  // MMIO load: single-word read, one idle cycle before the beat
  task automatic mmio_load(input logic [31:0] addr, input logic [31:0] data, input string tag);
    cpu_addr = addr;
    cpu_re   = 1'b1;
    @(negedge clk);
    check({tag, "_stall_t1"}, 32'(stall), 32'd1);
    cpu_re = 1'b0;
    @(negedge clk);
    wait_req(tag);
    check({tag, "_burst"}, 32'(mem_req_burst), 32'd0);
    check({tag, "_addr"}, mem_req_addr, addr);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check({tag, "_wait_stall"}, 32'(stall), 32'd1);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check({tag, "_resp_stall"}, 32'(stall), 32'd0);
    check({tag, "_resp_dout"}, cpu_dout, data);
    @(negedge clk);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    cpu_addr       = '0;
    cpu_re         = 1'b0;
    cpu_we         = 4'h0;
    cpu_din        = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_dout", cpu_dout, 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Cold miss, then hits on the refilled line (back-to-back)
    load_miss(32'h0000_0104, 32'hA0, 32'hA1, 32'h0000_0100, "cold");
    cpu_addr = 32'h0000_0108;
    cpu_re   = 1'b1;
    @(negedge clk);
    check("hit2_stall", 32'(stall), 32'd0);
    check("hit2_dout", cpu_dout, 32'hA2);
    check("hit2_noreq", 32'(mem_req_valid), 32'd0);
    cpu_addr = 32'h0000_010C;
    @(negedge clk);
    cpu_re = 1'b0;
    check("hit3_stall", 32'(stall), 32'd0);
    check("hit3_dout", cpu_dout, 32'hA3);
    @(negedge clk);
    check("hold_dout", cpu_dout, 32'hA3);
    check("hold_noreq", 32'(mem_req_valid), 32'd0);

    // Stores: write-through with byte merge into the cached line
    do_store(32'h0000_0104, 4'b0011, 32'h0000_BEEF, 3, 4, "st1");
    load_hit(32'h0000_0104, 32'h0000_BEEF, "st1_rd");
    do_store(32'h0000_010C, 4'b1000, 32'h5500_0000, 0, 1, "st2");
    load_hit(32'h0000_010C, 32'h5500_00A3, "st2_rd");

    // Store miss does not allocate
    do_store(32'h0000_3008, 4'hF, 32'h1234_5678, 1, 2, "stm");
    load_miss(32'h0000_3008, 32'hE0, 32'hE2, 32'h0000_3000, "stm_rd");

    // Same index, new tag evicts; original address then misses
    load_miss(32'h0000_1104, 32'hB0, 32'hB1, 32'h0000_1100, "evict");
    load_hit(32'h0000_1108, 32'hB2, "evict_hit");
    load_miss(32'h0000_0104, 32'hA0, 32'hA1, 32'h0000_0100, "reload");

    // MMIO loads never allocate
    mmio_load(32'h8000_0010, 32'hCAFE_0010, "mmio1");
    mmio_load(32'h8000_0010, 32'hCAFE_0011, "mmio2");

    // Reset during refill beat 2
    cpu_addr = 32'h0000_0200;
    cpu_re   = 1'b1;
    @(negedge clk);
    cpu_re = 1'b0;
    @(negedge clk);
    wait_req("rmid");
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'hC0 + 32'(i);
      @(negedge clk);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hC2;
    #1 reset = 1'b1;
    #1;
    check("rmid_stall", 32'(stall), 32'd0);
    check("rmid_req_valid", 32'(mem_req_valid), 32'd0);
    check("rmid_state", 32'(dbg_state), 32'(ST_IDLE));
    mem_resp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    load_miss(32'h0000_0200, 32'hC0, 32'hC0, 32'h0000_0200, "rmid_re");
    load_miss(32'h0000_0108, 32'hD0, 32'hD2, 32'h0000_0100, "rst_inv");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
